// File: rtl/pz_pkg.sv
// Shared types and packing helpers for the pole/zero slew sequencer.
// Component c maps to entry c>>1; even c is re (low half), odd c is im.
package pz_pkg;

  localparam int COORD_W   = 16;
  localparam int N_ENTRIES = 8;
  localparam int N_COMP    = 2 * N_ENTRIES;
  localparam int ENTRY_W   = 2 * COORD_W;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    WAIT_FRAME
  } state_t;

  function automatic int comp_entry(input int c);
    return c >> 1;
  endfunction

  function automatic bit comp_is_im(input int c);
    return c[0];
  endfunction

  function automatic int comp_lsb(input int c);
    return comp_entry(c) * ENTRY_W
         + (comp_is_im(c) ? COORD_W : 0);
  endfunction

  function automatic logic [ENTRY_W-1:0] pack_entry(
    input logic [COORD_W-1:0] im,
    input logic [COORD_W-1:0] re
  );
    return {im, re};
  endfunction

endpackage

// File: rtl/pz_slew_step.sv
// Shared signed slew adder: moves cur toward tgt by at most step.
// step == 0 means snap straight to the target.
module pz_slew_step #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] cur,
  input  logic signed [W-1:0] tgt,
  input  logic        [W-1:0] step,
  output logic signed [W-1:0] nxt
);

  logic signed [W:0] diff;
  logic        [W:0] mag;
  logic        [W:0] sum;

  // Clamp the move; the result always lies between cur and tgt.
  always_comb begin
    diff = {tgt[W-1], tgt} - {cur[W-1], cur};
    mag  = diff[W] ? 0 - diff : diff;
    sum  = '0;
    nxt  = tgt;
    if (step != '0 && mag > {1'b0, step}) begin
      if (diff[W])
        sum = {cur[W-1], cur} - {1'b0, step};
      else
        sum = {cur[W-1], cur} + {1'b0, step};
      nxt = sum[W-1:0];
    end
  end

endmodule

// File: rtl/pz_slew_sequencer.sv
// Rate-limited pole/zero update sequencer; one shared slew adder
// walks all components, publishing only on frame boundaries.
module pz_slew_sequencer
  import pz_pkg::*;
#(
  parameter int N_ENTRIES = 8,
  parameter int COORD_W   = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_ENTRIES*2*COORD_W-1:0] target_in,
  input  logic                           commit,
  input  logic [COORD_W-1:0]             step,
  input  logic                           frame_done,
  output logic [N_ENTRIES*COORD_W-1:0]   zeroes_out,
  output logic [N_ENTRIES*COORD_W-1:0]   poles_out,
  output logic                           busy,
  output logic                           settled,
  output logic                           published
);

  localparam int NC    = 2 * N_ENTRIES;
  localparam int IDX_W = $clog2(NC);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NC - 1);

  logic [NC-1:0][COORD_W-1:0] target_q;
  logic [NC-1:0][COORD_W-1:0] active_q;
  logic [NC-1:0][COORD_W-1:0] working_q;
  logic [IDX_W-1:0]           idx;
  logic [COORD_W-1:0]         slew_nxt;
  state_t                     state;
  logic                       work_done;

  pz_slew_step #(.W(COORD_W)) u_step (
    .cur  (active_q[idx]),
    .tgt  (target_q[idx]),
    .step (step),
    .nxt  (slew_nxt)
  );

  assign zeroes_out = active_q[NC/2-1:0];
  assign poles_out  = active_q[NC-1:NC/2];
  assign work_done  = (working_q == target_q);

  // Sequencer FSM: latch targets, slew one component per cycle,
  // publish the working set on the next frame boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target_q  <= '0;
      active_q  <= '0;
      working_q <= '0;
      idx       <= '0;
      state     <= IDLE;
      busy      <= 1'b0;
      settled   <= 1'b1;
      published <= 1'b0;
    end else begin
      published <= 1'b0;
      unique case (state)
        IDLE: begin
          if (commit) begin
            target_q <= target_in;
            settled  <= (active_q == target_in);
            idx      <= '0;
            state    <= CALC;
            busy     <= 1'b1;
          end
        end
        CALC: begin
          if (commit) begin
            target_q <= target_in;
            settled  <= (active_q == target_in);
            idx      <= '0;
          end else begin
            working_q[idx] <= slew_nxt;
            idx            <= idx + 1'b1;
            if (idx == LAST)
              state <= WAIT_FRAME;
          end
        end
        WAIT_FRAME: begin
          if (frame_done) begin
            active_q  <= working_q;
            published <= 1'b1;
            idx       <= '0;
            if (commit) begin
              target_q <= target_in;
              settled  <= (working_q == target_in);
              state    <= CALC;
              busy     <= 1'b1;
            end else begin
              settled <= work_done;
              state   <= work_done ? IDLE : CALC;
              busy    <= !work_done;
            end
          end else if (commit) begin
            target_q <= target_in;
            settled  <= (active_q == target_in);
            idx      <= '0;
            state    <= CALC;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pz_slew_sequencer.sv
// Directed bench for pz_slew_sequencer with a publish scoreboard.
// Expected active sets are queued at frame_done, popped on published.
module tb_pz_slew_sequencer;
  import pz_pkg::*;

  localparam int VW = 256;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [VW-1:0]   target_in = '0;
  logic            commit = 1'b0;
  logic [15:0]     step = '0;
  logic            frame_done = 1'b0;
  logic [127:0]    zeroes_out;
  logic [127:0]    poles_out;
  logic            busy;
  logic            settled;
  logic            published;

  int n_checks = 0;
  int n_pass   = 0;
  int n_pub    = 0;
  int pub_mark;

  logic [VW-1:0] sb[$];
  logic [VW-1:0] tb_tgt;

  always #5 clk = ~clk;

  pz_slew_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .target_in  (target_in),
    .commit     (commit),
    .step       (step),
    .frame_done (frame_done),
    .zeroes_out (zeroes_out),
    .poles_out  (poles_out),
    .busy       (busy),
    .settled    (settled),
    .published  (published)
  );

  task automatic chk(
    input string         name,
    input logic [VW-1:0] act,
    input logic [VW-1:0] exp
  );
    n_checks++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
  endtask

  function automatic logic [VW-1:0] cv(
    input int c,
    input logic [15:0] v
  );
    logic [VW-1:0] r;
    r = '0;
    r[comp_lsb(c) +: 16] = v;
    return r;
  endfunction

  // Monitor: every publish pulse pops one expected active set.
  always @(negedge clk) begin : mon
    logic [VW-1:0] e;
    if (!reset && published) begin
      n_pub++;
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_publish: got %h expected none",
                 {poles_out, zeroes_out});
      end else begin
        e = sb.pop_front();
        chk("publish", {poles_out, zeroes_out}, e);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic do_commit(input logic [VW-1:0] t);
    target_in = t;
    commit    = 1'b1;
    cyc(1);
    commit    = 1'b0;
  endtask

  task automatic do_frame(input logic [VW-1:0] e);
    sb.push_back(e);
    frame_done = 1'b1;
    cyc(1);
    frame_done = 1'b0;
    cyc(1);
    chk("publish_seen", VW'(sb.size()), '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    cyc(3);
    reset = 1'b0;

    // Idle after reset
    cyc(100);
    chk("rst_zeroes", VW'(zeroes_out), '0);
    chk("rst_poles", VW'(poles_out), '0);
    chk("rst_settled", VW'(settled), VW'(1));
    chk("rst_busy", VW'(busy), '0);
    chk("rst_no_pub", VW'(n_pub), '0);

    // Snap with step 0
    step   = 16'h0000;
    tb_tgt = cv(0, 16'hFF00) | cv(1, 16'h0100);
    do_commit(tb_tgt);
    cyc(20);
    chk("snap_busy_wait", VW'(busy), VW'(1));
    do_frame(tb_tgt);
    chk("snap_entry0", VW'(zeroes_out[31:0]),
        VW'(32'h0100FF00));
    chk("snap_settled", VW'(settled), VW'(1));
    chk("snap_idle", VW'(busy), '0);

    // Ramp pole 4 re in 0x40 steps
    do_reset();
    step = 16'h0040;
    do_commit(cv(8, 16'h0100));
    for (int k = 1; k <= 4; k++) begin
      cyc(48);
      do_frame(cv(8, 16'(k * 64)));
      chk("ramp_settled", VW'(settled), VW'(k == 4));
      chk("ramp_busy", VW'(busy), VW'(k != 4));
    end

    // Negative slew toward -32768
    do_reset();
    step = 16'h0000;
    do_commit(cv(0, 16'h0010));
    cyc(20);
    do_frame(cv(0, 16'h0010));
    step = 16'h7FFF;
    do_commit(cv(0, 16'h8000));
    cyc(20);
    do_frame(cv(0, 16'h8011));
    chk("neg_mid_settled", VW'(settled), '0);
    cyc(20);
    do_frame(cv(0, 16'h8000));
    chk("neg_settled", VW'(settled), VW'(1));

    // Re-commit mid CALC, frame ends during CALC
    do_reset();
    step = 16'h0000;
    do_commit(cv(2, 16'h1234));
    cyc(6);
    tb_tgt = cv(2, 16'h5678) | cv(3, 16'h0001);
    do_commit(tb_tgt);
    cyc(2);
    pub_mark   = n_pub;
    frame_done = 1'b1;
    cyc(1);
    frame_done = 1'b0;
    cyc(2);
    chk("abort_no_pub", VW'(n_pub - pub_mark), '0);
    chk("abort_held", VW'(zeroes_out), '0);
    cyc(20);
    do_frame(tb_tgt);
    chk("abort_settled", VW'(settled), VW'(1));

    // Commit coincident with frame_done
    do_reset();
    step = 16'h0010;
    do_commit(cv(0, 16'h0020));
    cyc(20);
    sb.push_back(cv(0, 16'h0010));
    target_in  = cv(0, 16'h0030);
    commit     = 1'b1;
    frame_done = 1'b1;
    cyc(1);
    commit     = 1'b0;
    frame_done = 1'b0;
    cyc(1);
    chk("coin_pub_seen", VW'(sb.size()), '0);
    chk("coin_busy", VW'(busy), VW'(1));
    cyc(20);
    do_frame(cv(0, 16'h0020));
    cyc(20);
    do_frame(cv(0, 16'h0030));
    chk("coin_settled", VW'(settled), VW'(1));
    chk("coin_idle", VW'(busy), '0);

    cyc(5);
    chk("sb_empty", VW'(sb.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pz_slew_sequencer.md
Name: pz_slew_sequencer

Overview:
- Controller sitting between the AXI-Lite pole/zero register file and the per-frame latch feeding the complex-subtract/phase datapath.
- Rate-limits pole/zero motion: each frame, moves every active coordinate toward its committed target by at most `step`, so the rendered plot animates instead of jumping.
- Time-shares one signed slew adder across all 16 coordinates, one per cycle.
- Publishes a new set only in the cycle after frame_done (end-of-frame tlast handshake), so the active set never changes mid-frame.

Parameters:
- N_ENTRIES, 8, number of complex entries; entries 0-3 are zeroes, 4-7 are poles.
- COORD_W, 16, signed width of each real/imag component; entry word is {im, re}, 2*COORD_W bits.

Ports:
- clk  in  1  stream clock (out_stream_aclk domain).
- reset  in  1  asynchronous, active-high reset.
- target_in  in  N_ENTRIES*2*COORD_W  committed set; entry k at [k*32+:32], re in low half.
- commit  in  1  single-cycle pulse; latch target_in as the new target.
- step  in  COORD_W  unsigned max per-frame move per component; 0 = snap directly to target.
- frame_done  in  1  single-cycle pulse at end of frame (tlast AND tready).
- zeroes_out  out  4*2*COORD_W  active entries 0-3.
- poles_out  out  4*2*COORD_W  active entries 4-7.
- busy  out  1  high in CALC or WAIT_FRAME.
- settled  out  1  active == target (all 16 components).
- published  out  1  single-cycle pulse in the cycle active is updated.

Behaviour:
- Reset (async): active, working and target regs = 0; state IDLE; idx = 0; busy = 0; settled = 1; published = 0.
- Registers: target[16], active[16], working[16] components, plus a 4-bit idx; component c = entry c>>1, re if c even, im if odd.
- Slew arithmetic:
  - diff = target[c] - active[c], computed at COORD_W+1 bits signed.
  - If step == 0 or |diff| <= step: working[c] = target[c].
  - Else working[c] = active[c] + step when diff > 0, or active[c] - step when diff < 0.
  - The result always lies between active and target, so it cannot overflow.
- States:
  - IDLE: on commit, latch target and go to CALC with idx = 0.
  - CALC: compute working[idx] and increment idx; after idx 15 is computed (16 cycles), go to WAIT_FRAME.
  - WAIT_FRAME: on frame_done, active <= working and published = 1 for that cycle. Then:
    - go to IDLE if working == target;
    - otherwise go to CALC with idx = 0.
- Latency: commit to first publish is 16 cycles of CALC plus the wait for the next frame_done; publish happens one cycle after the frame_done edge.
- Commit during CALC: latch target, restart at idx = 0 (abort in progress). working is always derived from active, so a restart is safe.
- Commit during WAIT_FRAME without frame_done: latch target, go to CALC with idx = 0; nothing is published this frame.
- Commit and frame_done in the same cycle in WAIT_FRAME: publish the old working set first, then latch the new target, go to CALC.
- frame_done during CALC or IDLE: ignored; active is held, published = 0. A frame that ends during CALC gets no update.
- settled is registered and recomputed whenever active or target changes. It may be 1 while state is CALC if target == active (e.g. a re-commit of the same set); the next publish then leaves active unchanged.
- step is sampled combinationally during CALC; changing it mid-CALC is allowed but mixes step values within one frame.
- Reset mid-operation: immediate return to the reset values; any in-progress update is lost.

Decomposition:
- Package pz_pkg holds:
  - COORD_W and N_ENTRIES;
  - state encoding (IDLE, CALC, WAIT_FRAME);
  - component index helpers (entry, re/im select);
  - the {im, re} packing convention.
- One sub-module, pz_slew_step: combinational clamp taking (cur, tgt, step) and returning next; instantiated once as the shared adder.

Test Plan:
- Reset, then idle 100 cycles -> outputs all 0, settled = 1, busy = 0, published never asserts.
- step = 0; commit entry0 = {im 0x0100, re 0xFF00}; frame_done after 20 cycles -> one published pulse, zeroes_out[31:0] = 0x0100FF00, settled = 1, state IDLE.
- step = 0x40; commit entry4 re = 0x0100, all else 0; pulse frame_done every 50 cycles -> poles_out re takes 0x0040, 0x0080, 0x00C0, 0x0100 on 4 publishes; settled rises after the 4th.
- Negative slew: active re = 0x0010, target re = 0x8000 (-32768), step = 0x7FFF -> after 1st publish re = 0x8011 (-32751), after 2nd re = 0x8000; no wrap.
- Commit a new target on CALC cycle 7, frame_done on cycle 10 -> no publish that frame; CALC restarts at idx 0; the next publish reflects only the new target.
- Commit coincident with frame_done in WAIT_FRAME -> published = 1 with the old working set; busy stays 1; the following publish moves toward the new target.
